// File: rtl/fde_core_if.sv
// Instruction-ROM port of the FDE core: address out, combinational instruction word back.
// Zero latency (pure wires); no backpressure, the ROM answers every address in the same cycle.
interface fde_core_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 10
);
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fde_core.sv
// Parametrised fetch-decode-execute core with run/stop and single-step control.
// Latency: fixed 3 cycles per instruction (FETCH, DECODE, EXECUTE); HALT is terminal until reset.
// Backpressure: stop=1 parks the core at FETCH; each registered step edge releases one instruction.
module fde_core #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2,
    parameter int PC_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stop,
    input  logic              step,
    fde_core_if.master        imem,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    output logic [DATA_W-1:0] result,
    output logic [PC_W-1:0]   pc,
    output logic [1:0]        state,
    output logic              halted
);
    localparam int INSTR_W = 4 + 3 * RA_W;
    localparam int NREGS   = 2 ** RA_W;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALT   = 2'b11
    } state_t;

    state_t              cur_st, nxt_st;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NREGS];
    logic                step_prev, step_pend;
    logic                run_ok, ir_load;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_val;
    logic [PC_W-1:0]     pc_nxt;
    logic [DATA_W-1:0]   imm;
    logic [PC_W-1:0]     tgt;

    logic [3:0]          ir_op;
    logic [RA_W-1:0]     ir_dst, ir_src1, ir_src2;

    assign ir_op   = ir[INSTR_W-1 -: 4];
    assign ir_dst  = ir[3*RA_W-1 -: RA_W];
    assign ir_src1 = ir[2*RA_W-1 -: RA_W];
    assign ir_src2 = ir[RA_W-1:0];

    // Immediate {src1,src2} and jump target {dst,src1,src2}: zero-extend or truncate per bit.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm
        if (gi < 2 * RA_W) begin : g_bit
            assign imm[gi] = ir[gi];
        end else begin : g_zero
            assign imm[gi] = 1'b0;
        end
    end

    for (genvar gj = 0; gj < PC_W; gj++) begin : g_tgt
        if (gj < 3 * RA_W) begin : g_bit
            assign tgt[gj] = ir[gj];
        end else begin : g_zero
            assign tgt[gj] = 1'b0;
        end
    end

    assign run_ok         = !stop || step_pend;
    assign imem.imem_addr = pc;
    assign state          = cur_st;
    assign halted         = (cur_st == ST_HALT);

    always_comb begin
        nxt_st  = cur_st;
        ir_load = 1'b0;
        case (cur_st)
            ST_FETCH: begin
                if (run_ok) begin
                    nxt_st  = ST_DECODE;
                    ir_load = 1'b1;
                end
            end
            ST_DECODE: nxt_st = ST_EXEC;
            ST_EXEC:   nxt_st = (opcode == 4'hF) ? ST_HALT : ST_FETCH;
            ST_HALT:   nxt_st = ST_HALT;
            default:   nxt_st = ST_FETCH;
        endcase
    end

    // EXECUTE works from the operands latched in DECODE, so a write never races its own read.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = '0;
        pc_nxt = pc + PC_W'(1);
        case (opcode)
            4'h1: begin wr_en = 1'b1; wr_val = operand_1 + operand_2; end
            4'h2: begin wr_en = 1'b1; wr_val = operand_1 - operand_2; end
            4'h3: begin wr_en = 1'b1; wr_val = operand_1 & operand_2; end
            4'h4: begin wr_en = 1'b1; wr_val = operand_1 | operand_2; end
            4'h5: begin wr_en = 1'b1; wr_val = operand_1 ^ operand_2; end
            4'h6: begin wr_en = 1'b1; wr_val = imm; end
            4'h7: pc_nxt = tgt;
            4'h8: if (operand_1 == '0) pc_nxt = tgt;
            4'hF: pc_nxt = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_st    <= ST_FETCH;
            ir        <= '0;
            step_prev <= 1'b0;
            step_pend <= 1'b0;
            opcode    <= '0;
            operand_1 <= '0;
            operand_2 <= '0;
            result    <= '0;
            pc        <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            cur_st    <= nxt_st;
            step_prev <= step;

            // A new edge wins over consumption so back-to-back pulses are never lost.
            if (cur_st == ST_HALT)
                step_pend <= 1'b0;
            else if (step && !step_prev && stop)
                step_pend <= 1'b1;
            else if (ir_load)
                step_pend <= 1'b0;

            if (ir_load)
                ir <= imem.imem_data;

            if (cur_st == ST_DECODE) begin
                opcode    <= ir_op;
                operand_1 <= regs[ir_src1];
                operand_2 <= regs[ir_src2];
            end

            if (cur_st == ST_EXEC) begin
                pc <= pc_nxt;
                if (wr_en) begin
                    regs[ir_dst] <= wr_val;
                    result       <= wr_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_fde_core.sv
// Bench for fde_core: default instance (8/2/4) and a wide instance (16/3/6) against an instruction-level model.
module tb_fde_core;
    logic clk;
    logic rst_a, stop_a, step_a;
    logic rst_b, stop_b, step_b;

    logic [3:0]  op_a;
    logic [7:0]  opd1_a, opd2_a, res_a;
    logic [3:0]  pc_a;
    logic [1:0]  st_a;
    logic        hlt_a;

    logic [3:0]  op_b;
    logic [15:0] opd1_b, opd2_b, res_b;
    logic [5:0]  pc_b;
    logic [1:0]  st_b;
    logic        hlt_b;

    logic [9:0]  rom_a [16];
    logic [12:0] rom_b [64];

    int n_pass = 0;
    int n_total = 0;

    int m_pc, m_res, m_op, m_op1, m_op2;
    int m_regs [8];
    bit m_halt;

    fde_core_if #(.PC_W(4), .INSTR_W(10)) bus_a ();
    fde_core_if #(.PC_W(6), .INSTR_W(13)) bus_b ();

    assign bus_a.imem_data = rom_a[bus_a.imem_addr];
    assign bus_b.imem_data = rom_b[bus_b.imem_addr];

    fde_core #(.DATA_W(8), .RA_W(2), .PC_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .stop(stop_a), .step(step_a), .imem(bus_a),
        .opcode(op_a), .operand_1(opd1_a), .operand_2(opd2_a), .result(res_a),
        .pc(pc_a), .state(st_a), .halted(hlt_a)
    );

    fde_core #(.DATA_W(16), .RA_W(3), .PC_W(6)) dut_b (
        .clk(clk), .reset(rst_b), .stop(stop_b), .step(step_b), .imem(bus_b),
        .opcode(op_b), .operand_1(opd1_b), .operand_2(opd2_b), .result(res_b),
        .pc(pc_b), .state(st_b), .halted(hlt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int enc(input int raw, input int op, input int d, input int s1, input int s2);
        return (op << (3 * raw)) | (d << (2 * raw)) | (s1 << raw) | s2;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_res = 0; m_op = 0; m_op1 = 0; m_op2 = 0; m_halt = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
    endtask

    // One whole instruction, straight from the ISA table.
    task automatic model_exec(input int dw, input int raw, input int pcw, input int ins);
        int op, d, s1, s2, a, b, w, npc, rm, mask, pm;
        bit wr;
        rm   = (1 << raw) - 1;
        mask = (1 << dw) - 1;
        pm   = (1 << pcw) - 1;
        op   = (ins >> (3 * raw)) & 15;
        d    = (ins >> (2 * raw)) & rm;
        s1   = (ins >> raw) & rm;
        s2   = ins & rm;
        a    = m_regs[s1];
        b    = m_regs[s2];
        m_op = op; m_op1 = a; m_op2 = b;
        npc  = (m_pc + 1) & pm;
        wr   = 1; w = 0;
        case (op)
            1: w = (a + b) & mask;
            2: w = (a - b) & mask;
            3: w = a & b;
            4: w = a | b;
            5: w = a ^ b;
            6: w = ins & ((1 << (2 * raw)) - 1) & mask;
            7: begin wr = 0; npc = ins & ((1 << (3 * raw)) - 1) & pm; end
            8: begin wr = 0; if (a == 0) npc = ins & ((1 << (3 * raw)) - 1) & pm; end
            15: begin wr = 0; npc = m_pc; m_halt = 1; end
            default: wr = 0;
        endcase
        if (wr) begin
            m_regs[d] = w;
            m_res = w;
        end
        m_pc = npc;
    endtask

    task automatic fill_nop_a();
        for (int i = 0; i < 16; i++) rom_a[i] = '0;
    endtask

    task automatic fill_nop_b();
        for (int i = 0; i < 64; i++) rom_b[i] = '0;
    endtask

    // Reset with stop held so nothing runs until the caller releases it.
    task automatic reset_a();
        stop_a = 1'b1;
        step_a = 1'b0;
        rst_a  = 1'b0;
        tick();
        rst_a  = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        fill_nop_a();
        stop_a = 1'b1;
        step_a = 1'b0;
        rst_a  = 1'b0;
        #1;
        n_total++; if (pc_a !== 4'd0) $display("FAIL reset_pc: got %0h want 0", pc_a); else n_pass++;
        n_total++; if (st_a !== 2'b00) $display("FAIL reset_state: got %0b want 00", st_a); else n_pass++;
        n_total++; if (res_a !== 8'd0) $display("FAIL reset_result: got %0h want 0", res_a); else n_pass++;
        n_total++; if (hlt_a !== 1'b0) $display("FAIL reset_halted: got %0b want 0", hlt_a); else n_pass++;
        n_total++; if (op_a !== 4'd0) $display("FAIL reset_opcode: got %0h want 0", op_a); else n_pass++;
        tick();
        rst_a = 1'b1;
        model_reset();
        repeat (5) tick();
        n_total++; if (pc_a !== 4'd0) $display("FAIL stop_hold_pc: got %0h want 0", pc_a); else n_pass++;
        n_total++; if (st_a !== 2'b00) $display("FAIL stop_hold_state: got %0b want 00", st_a); else n_pass++;
    endtask

    task automatic test_arith();
        logic [7:0] exp_res [4];
        exp_res[0] = 8'h0F; exp_res[1] = 8'h03; exp_res[2] = 8'h12; exp_res[3] = 8'hF4;
        fill_nop_a();
        rom_a[0] = 10'(enc(2, 6, 1, 3, 3));
        rom_a[1] = 10'(enc(2, 6, 2, 0, 3));
        rom_a[2] = 10'(enc(2, 1, 3, 1, 2));
        rom_a[3] = 10'(enc(2, 2, 0, 2, 1));
        reset_a();
        stop_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); tick();
            n_total++;
            if (st_a !== 2'b10 || pc_a !== 4'(i))
                $display("FAIL arith_mid%0d: state %0b pc %0h want 10 %0h", i, st_a, pc_a, i);
            else n_pass++;
            tick();
            model_exec(8, 2, 4, int'(rom_a[m_pc]));
            n_total++;
            if (res_a !== exp_res[i] || pc_a !== 4'(i + 1) || st_a !== 2'b00)
                $display("FAIL arith%0d: result %0h pc %0h state %0b want %0h %0h 00",
                         i, res_a, pc_a, st_a, exp_res[i], i + 1);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_jump();
        logic [3:0] exp_pc [4];
        exp_pc[0] = 4'd1; exp_pc[1] = 4'd5; exp_pc[2] = 4'd6; exp_pc[3] = 4'd2;
        fill_nop_a();
        reset_a();
        stop_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            repeat (3) tick();
            model_exec(8, 2, 4, int'(rom_a[m_pc]));
        end
        n_total++; if (pc_a !== 4'd0) $display("FAIL wrap_pc: got %0h want 0", pc_a); else n_pass++;

        rom_a[0] = 10'(enc(2, 6, 1, 0, 1));
        rom_a[1] = 10'(enc(2, 7, 0, 1, 1));
        rom_a[5] = 10'(enc(2, 8, 0, 1, 3));
        rom_a[6] = 10'(enc(2, 8, 0, 0, 2));
        reset_a();
        stop_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (3) tick();
            n_total++;
            if (pc_a !== exp_pc[i]) $display("FAIL jump%0d_pc: got %0h want %0h", i, pc_a, exp_pc[i]);
            else n_pass++;
        end
    endtask

    task automatic test_single_step();
        logic [3:0] p;
        fill_nop_a();
        reset_a();
        for (int k = 0; k < 3; k++) begin
            step_a = 1'b1; tick();
            step_a = 1'b0; repeat (6) tick();
        end
        n_total++;
        if (pc_a !== 4'd3 || st_a !== 2'b00) $display("FAIL step3: pc %0h state %0b want 3 00", pc_a, st_a);
        else n_pass++;
        step_a = 1'b1;
        repeat (20) tick();
        n_total++; if (pc_a !== 4'd4) $display("FAIL step_held: pc %0h want 4", pc_a); else n_pass++;
        step_a = 1'b0;
        tick();
        stop_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_a = 1'b1; tick();
            step_a = 1'b0; tick();
        end
        stop_a = 1'b1;
        repeat (4) tick();
        p = pc_a;
        repeat (10) tick();
        n_total++;
        if (pc_a !== p || st_a !== 2'b00) $display("FAIL step_while_run: pc %0h state %0b want %0h 00", pc_a, st_a, p);
        else n_pass++;
    endtask

    task automatic test_halt();
        fill_nop_a();
        rom_a[2] = 10'(enc(2, 15, 0, 0, 0));
        reset_a();
        stop_a = 1'b0;
        repeat (9) tick();
        n_total++;
        if (st_a !== 2'b11 || hlt_a !== 1'b1 || pc_a !== 4'd2)
            $display("FAIL halt_enter: state %0b halted %0b pc %0h want 11 1 2", st_a, hlt_a, pc_a);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            stop_a = 1'($urandom_range(0, 1));
            step_a = 1'($urandom_range(0, 1));
            tick();
            n_total++;
            if (st_a !== 2'b11 || hlt_a !== 1'b1 || pc_a !== 4'd2)
                $display("FAIL halt_sticky%0d: state %0b halted %0b pc %0h", i, st_a, hlt_a, pc_a);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        fill_nop_a();
        rom_a[0] = 10'(enc(2, 6, 1, 1, 1));
        rom_a[1] = 10'(enc(2, 6, 2, 1, 3));
        rom_a[2] = 10'(enc(2, 1, 3, 1, 2));
        reset_a();
        stop_a = 1'b0;
        repeat (6) tick();
        n_total++; if (res_a !== 8'h07) $display("FAIL mid_pre: result %0h want 07", res_a); else n_pass++;
        tick(); tick();
        n_total++; if (st_a !== 2'b10) $display("FAIL mid_exec: state %0b want 10", st_a); else n_pass++;
        #2 rst_a = 1'b0;
        #1;
        n_total++;
        if (pc_a !== 4'd0 || st_a !== 2'b00 || res_a !== 8'd0)
            $display("FAIL mid_reset: pc %0h state %0b result %0h want 0 00 0", pc_a, st_a, res_a);
        else n_pass++;
        stop_a = 1'b1;
        tick();
        rst_a = 1'b1;
        model_reset();
        rom_a[0] = 10'(enc(2, 4, 0, 3, 3));
        stop_a = 1'b0;
        repeat (3) tick();
        n_total++;
        if (res_a !== 8'd0 || opd1_a !== 8'd0 || op_a !== 4'd4)
            $display("FAIL mid_r3: result %0h operand_1 %0h opcode %0h want 0 0 4", res_a, opd1_a, op_a);
        else n_pass++;
    endtask

    task automatic test_random_a();
        int op;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
                rom_a[i] = 10'(enc(2, op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
            end
            reset_a();
            stop_a = 1'b0;
            for (int n = 0; n < 30; n++) begin
                repeat (3) tick();
                if (!m_halt) model_exec(8, 2, 4, int'(rom_a[m_pc]));
                n_total++;
                if (pc_a !== 4'(m_pc) || res_a !== 8'(m_res) || op_a !== 4'(m_op) ||
                    opd1_a !== 8'(m_op1) || opd2_a !== 8'(m_op2) || st_a !== (m_halt ? 2'b11 : 2'b00))
                    $display("FAIL rand_a r%0d n%0d: pc %0h res %0h op %0h o1 %0h o2 %0h st %0b want %0h %0h %0h %0h %0h h%0b",
                             r, n, pc_a, res_a, op_a, opd1_a, opd2_a, st_a, m_pc, m_res, m_op, m_op1, m_op2, m_halt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_params();
        logic [15:0] exp_res [7];
        int op;
        exp_res[0] = 16'h003F; exp_res[1] = 16'h0003; exp_res[2] = 16'h0042; exp_res[3] = 16'hFFC4;
        exp_res[4] = 16'h0001; exp_res[5] = 16'hFFFF; exp_res[6] = 16'h0000;
        fill_nop_b();
        rom_b[0] = 13'(enc(3, 6, 1, 7, 7));
        rom_b[1] = 13'(enc(3, 6, 2, 0, 3));
        rom_b[2] = 13'(enc(3, 1, 3, 1, 2));
        rom_b[3] = 13'(enc(3, 2, 0, 2, 1));
        rom_b[4] = 13'(enc(3, 6, 5, 0, 1));
        rom_b[5] = 13'(enc(3, 2, 4, 7, 5));
        rom_b[6] = 13'(enc(3, 1, 6, 4, 5));
        stop_b = 1'b1; step_b = 1'b0; rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        stop_b = 1'b0;
        for (int i = 0; i < 7; i++) begin
            repeat (3) tick();
            n_total++;
            if (res_b !== exp_res[i] || pc_b !== 6'(i + 1))
                $display("FAIL wide%0d: result %0h pc %0h want %0h %0h", i, res_b, pc_b, exp_res[i], i + 1);
            else n_pass++;
        end

        for (int i = 0; i < 64; i++) begin
            op = $urandom_range(0, 8);
            rom_b[i] = 13'(enc(3, op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
        end
        stop_b = 1'b1; rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        model_reset();
        stop_b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            repeat (3) tick();
            model_exec(16, 3, 6, int'(rom_b[m_pc]));
            n_total++;
            if (pc_b !== 6'(m_pc) || res_b !== 16'(m_res) || op_b !== 4'(m_op) ||
                opd1_b !== 16'(m_op1) || opd2_b !== 16'(m_op2))
                $display("FAIL rand_b n%0d: pc %0h res %0h op %0h o1 %0h o2 %0h want %0h %0h %0h %0h %0h",
                         n, pc_b, res_b, op_b, opd1_b, opd2_b, m_pc, m_res, m_op, m_op1, m_op2);
            else n_pass++;
        end
        n_total++; if (hlt_b !== 1'b0) $display("FAIL wide_halted: got %0b want 0", hlt_b); else n_pass++;
    endtask

    initial begin
        rst_a = 1'b0; stop_a = 1'b1; step_a = 1'b0;
        rst_b = 1'b0; stop_b = 1'b1; step_b = 1'b0;
        fill_nop_a();
        fill_nop_b();
        model_reset();
        test_reset();
        test_arith();
        test_wrap_jump();
        test_single_step();
        test_halt();
        test_reset_mid();
        test_random_a();
        test_params();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
